// File: rtl/mac_pkg.sv
// Shared constants and types for the MAC vector feeder and its integration bench.
package mac_pkg;

    localparam int DATA_W  = 14;
    localparam int ACC_W   = 28;
    localparam int MAX_LEN = 16;

    // Saturation bounds of the MAC accumulator: [-2^(ACC_W-1), 2^(ACC_W-1)-1].
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [2:0] {
        LOAD,
        CLEAR,
        FEED,
        DRAIN,
        OUT
    } feeder_state_t;

endpackage

// File: rtl/feeder_opbuf.sv
// Operand-pair register file: synchronous write, combinational read.
module feeder_opbuf #(
    parameter int DATA_W = 14,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic signed [DATA_W-1:0] wr_a,
    input  logic signed [DATA_W-1:0] wr_b,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic signed [DATA_W-1:0] rd_a,
    output logic signed [DATA_W-1:0] rd_b
);

    logic [2*DATA_W-1:0] mem [DEPTH];

    // NOTE: the data array has no reset; every entry is written in LOAD before FEED reads it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= {wr_a, wr_b};
        end
    end

    assign rd_a = mem[rd_addr][2*DATA_W-1:DATA_W];
    assign rd_b = mem[rd_addr][DATA_W-1:0];

endmodule

// File: rtl/mac_vector_feeder.sv
// Buffers a dot-product job, clears the MAC, streams the pairs into it and
// returns the final saturated accumulator value on a ready/valid result port.
module mac_vector_feeder #(
    parameter int DATA_W  = mac_pkg::DATA_W,
    parameter int ACC_W   = mac_pkg::ACC_W,
    parameter int MAX_LEN = mac_pkg::MAX_LEN,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_valid,
    output logic                     load_ready,
    input  logic signed [DATA_W-1:0] load_a,
    input  logic signed [DATA_W-1:0] load_b,
    input  logic                     load_last,
    output logic                     mac_reset,
    output logic                     mac_valid_in,
    output logic signed [DATA_W-1:0] mac_a,
    output logic signed [DATA_W-1:0] mac_b,
    input  logic signed [ACC_W-1:0]  mac_f,
    input  logic                     mac_valid_out,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic signed [ACC_W-1:0]  res_data,
    output logic [LEN_W-1:0]         res_len
);

    import mac_pkg::*;

    localparam int ADDR_W = $clog2(MAX_LEN);

    feeder_state_t state, state_nxt;

    logic [LEN_W-1:0] wr_cnt;
    logic [LEN_W-1:0] rd_cnt;
    logic [LEN_W-1:0] out_cnt;
    logic [LEN_W-1:0] len;

    logic                     load_fire;
    logic                     job_last;
    logic                     counting;
    logic                     result_done;
    logic signed [DATA_W-1:0] buf_a;
    logic signed [DATA_W-1:0] buf_b;

    // load_fire is derived from state directly rather than from load_ready.
    assign load_fire   = load_valid && (state == LOAD);
    // The MAX_LEN-th pair closes the job even without load_last.
    assign job_last    = load_last || (wr_cnt == LEN_W'(MAX_LEN - 1));
    assign counting    = (state == FEED) || (state == DRAIN);
    assign result_done = counting && mac_valid_out && ((out_cnt + LEN_W'(1)) == len);

    feeder_opbuf #(
        .DATA_W (DATA_W),
        .DEPTH  (MAX_LEN),
        .ADDR_W (ADDR_W)
    ) u_opbuf (
        .clk     (clk),
        .wr_en   (load_fire),
        .wr_addr (wr_cnt[ADDR_W-1:0]),
        .wr_a    (load_a),
        .wr_b    (load_b),
        .rd_addr (rd_cnt[ADDR_W-1:0]),
        .rd_a    (buf_a),
        .rd_b    (buf_b)
    );

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        state_nxt    = state;
        load_ready   = 1'b0;
        mac_valid_in = 1'b0;
        res_valid    = 1'b0;
        unique case (state)
            LOAD: begin
                load_ready = 1'b1;
                if (load_fire && job_last) begin
                    state_nxt = CLEAR;
                end
            end
            CLEAR: state_nxt = FEED;
            FEED: begin
                mac_valid_in = 1'b1;
                if (rd_cnt == len - LEN_W'(1)) begin
                    state_nxt = DRAIN;
                end
                if (result_done) begin
                    state_nxt = OUT;
                end
            end
            DRAIN: begin
                if (result_done) begin
                    state_nxt = OUT;
                end
            end
            OUT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_nxt = LOAD;
                end
            end
            default: state_nxt = LOAD;
        endcase
    end

    assign mac_reset = reset || (state == CLEAR);
    assign mac_a     = (state == FEED) ? buf_a : '0;
    assign mac_b     = (state == FEED) ? buf_b : '0;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= LOAD;
            wr_cnt   <= '0;
            rd_cnt   <= '0;
            out_cnt  <= '0;
            len      <= '0;
            res_data <= '0;
            res_len  <= '0;
        end else begin
            state <= state_nxt;
            unique case (state)
                LOAD: begin
                    if (load_fire) begin
                        wr_cnt <= wr_cnt + LEN_W'(1);
                        if (job_last) begin
                            len <= wr_cnt + LEN_W'(1);
                        end
                    end
                end
                CLEAR: begin
                    rd_cnt  <= '0;
                    out_cnt <= '0;
                end
                FEED: rd_cnt <= rd_cnt + LEN_W'(1);
                DRAIN: ;
                OUT: begin
                    if (res_ready) begin
                        wr_cnt <= '0;
                    end
                end
                default: ;
            endcase
            if (counting && mac_valid_out) begin
                out_cnt <= out_cnt + LEN_W'(1);
            end
            if (result_done) begin
                res_data <= mac_f;
                res_len  <= len;
            end
        end
    end

endmodule

// File: tb/tb_mac_vector_feeder.sv
// Directed bench for mac_vector_feeder with a behavioural 3-cycle saturating MAC.
module tb_mac_vector_feeder;

    import mac_pkg::*;

    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     load_valid;
    logic                     load_ready;
    logic signed [DATA_W-1:0] load_a;
    logic signed [DATA_W-1:0] load_b;
    logic                     load_last;
    logic                     mac_reset;
    logic                     mac_valid_in;
    logic signed [DATA_W-1:0] mac_a;
    logic signed [DATA_W-1:0] mac_b;
    logic signed [ACC_W-1:0]  mac_f;
    logic                     mac_valid_out;
    logic                     res_valid;
    logic                     res_ready;
    logic signed [ACC_W-1:0]  res_data;
    logic [LEN_W-1:0]         res_len;

    int n_checks = 0;
    int n_pass   = 0;

    mac_vector_feeder dut (
        .clk           (clk),
        .reset         (reset),
        .load_valid    (load_valid),
        .load_ready    (load_ready),
        .load_a        (load_a),
        .load_b        (load_b),
        .load_last     (load_last),
        .mac_reset     (mac_reset),
        .mac_valid_in  (mac_valid_in),
        .mac_a         (mac_a),
        .mac_b         (mac_b),
        .mac_f         (mac_f),
        .mac_valid_out (mac_valid_out),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_data      (res_data),
        .res_len       (res_len)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural MAC: product, pipeline stage, saturating accumulate.
    logic signed [ACC_W-1:0] p1, p2;
    logic                    v1, v2;

    function automatic logic signed [ACC_W-1:0] sat(input logic signed [ACC_W:0] s);
        if (s > ACC_MAX) return ACC_MAX;
        if (s < ACC_MIN) return ACC_MIN;
        return s[ACC_W-1:0];
    endfunction

    always @(posedge clk) begin
        if (mac_reset) begin
            p1 <= '0; p2 <= '0; v1 <= 1'b0; v2 <= 1'b0;
            mac_f <= '0; mac_valid_out <= 1'b0;
        end else begin
            p1 <= mac_a * mac_b;
            v1 <= mac_valid_in;
            p2 <= p1;
            v2 <= v1;
            mac_valid_out <= v2;
            if (v2) mac_f <= sat(ACC_W'(mac_f) + p2);
        end
    end

    // Activity monitor for MAC clear and feed cycles.
    int clr_cnt = 0, clr_cyc = 0, feed_cnt = 0, feed_start = 0;
    logic feed_prev = 1'b0;
    always @(negedge clk) begin
        if (mac_reset && !reset) begin
            clr_cnt <= clr_cnt + 1;
            clr_cyc <= cyc;
        end
        if (mac_valid_in) feed_cnt <= feed_cnt + 1;
        if (mac_valid_in && !feed_prev) feed_start <= cyc;
        feed_prev <= mac_valid_in;
    end

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else n_pass++;
    endtask

    logic signed [DATA_W-1:0] ja [MAX_LEN];
    logic signed [DATA_W-1:0] jb [MAX_LEN];

    // Presents n pairs on consecutive cycles; returns the cycle of the final handshake.
    task automatic push_job(input int n, input bit mark_last, input bit extra, output int last_cyc);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            load_valid = 1'b1;
            load_a     = ja[i];
            load_b     = jb[i];
            load_last  = mark_last && (i == n - 1);
            last_cyc   = cyc;
        end
        @(negedge clk);
        if (extra) begin
            load_valid = 1'b1;
            load_a     = 14'sd100;
            load_b     = 14'sd100;
            load_last  = 1'b1;
            check("extra_pair_ready", load_ready, 0);
            repeat (2) @(negedge clk);
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic take_result(input string tag, input int l_cyc, input int exp_lat,
                               input longint exp_data, input int exp_len, input int hold);
        int waited = 0;
        while (!res_valid && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_res_valid"}, res_valid, 1);
        if (!res_valid) return;
        check({tag, "_latency"}, cyc - l_cyc, exp_lat);
        check({tag, "_data"}, res_data, exp_data);
        check({tag, "_len"}, res_len, exp_len);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_data"}, res_data, exp_data);
            check({tag, "_hold_load_ready"}, load_ready, 0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check({tag, "_valid_drop"}, res_valid, 0);
        check({tag, "_load_ready_back"}, load_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int l_cyc;
        int clr_base, feed_base;

        reset = 1'b1; load_valid = 1'b0; load_a = '0; load_b = '0; load_last = 1'b0; res_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_mac_reset", mac_reset, 1);
        reset = 1'b0;
        @(negedge clk);
        check("rst_load_ready", load_ready, 1);
        check("rst_mac_valid_in", mac_valid_in, 0);
        check("rst_mac_a", mac_a, 0);
        check("rst_mac_b", mac_b, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_res_len", res_len, 0);
        check("rst_mac_reset_low", mac_reset, 0);

        // 1*4 + 2*5 + 3*6 = 32
        ja[0] = 1; ja[1] = 2; ja[2] = 3;
        jb[0] = 4; jb[1] = 5; jb[2] = 6;
        push_job(3, 1'b1, 1'b0, l_cyc);
        take_result("dot3", l_cyc, 8, 32, 3, 0);

        // (-8192)^2 = 67108864
        ja[0] = -14'sd8192; jb[0] = -14'sd8192;
        push_job(1, 1'b1, 1'b0, l_cyc);
        take_result("single", l_cyc, 6, 67108864, 1, 0);

        // 3 * 8191^2 = 201277443 saturates to 134217727
        for (int i = 0; i < 3; i++) begin ja[i] = 14'sd8191; jb[i] = 14'sd8191; end
        clr_base  = clr_cnt;
        feed_base = feed_cnt;
        push_job(3, 1'b1, 1'b0, l_cyc);
        take_result("sat", l_cyc, 8, 134217727, 3, 0);
        check("sat_clear_cycles", clr_cnt - clr_base, 1);
        check("sat_clear_at", clr_cyc - l_cyc, 1);
        check("sat_feed_start", feed_start - l_cyc, 2);
        check("sat_feed_cycles", feed_cnt - feed_base, 3);

        // 1+2+...+16 = 136 with b=1, forced last, then 5-cycle result hold
        for (int i = 0; i < MAX_LEN; i++) begin ja[i] = DATA_W'(i + 1); jb[i] = 1; end
        push_job(MAX_LEN, 1'b0, 1'b1, l_cyc);
        take_result("full", l_cyc, 5 + MAX_LEN, 136, MAX_LEN, 5);

        // Reset in the second FEED cycle aborts the job.
        ja[0] = 5; ja[1] = 6; ja[2] = 7;
        jb[0] = 7; jb[1] = 8; jb[2] = 9;
        push_job(3, 1'b1, 1'b0, l_cyc);
        while (cyc < l_cyc + 3) @(negedge clk);
        check("abort_in_feed", mac_valid_in, 1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_mac_valid_in", mac_valid_in, 0);
        check("abort_load_ready", load_ready, 1);
        check("abort_mac_reset", mac_reset, 1);
        check("abort_res_valid", res_valid, 0);
        reset = 1'b0;
        @(negedge clk);
        check("abort_mac_reset_low", mac_reset, 0);

        ja[0] = 2; jb[0] = 3;
        push_job(1, 1'b1, 1'b0, l_cyc);
        take_result("post_abort", l_cyc, 6, 6, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
